// File: rtl/fc_argmax_pkg.sv
// fc_argmax_pkg: shared defaults and types for the final classification stage.
//   NUM_CLASSES_DEF / SCORE_W_DEF : defaults shared with the fc neuron stages
//   IDX_W_DEF                     : class index width derived from NUM_CLASSES_DEF
//   state_t                       : argmax FSM states
package fc_argmax_pkg;

  localparam int unsigned NUM_CLASSES_DEF = 10;
  localparam int unsigned SCORE_W_DEF     = 38;

  // Width needed to index n classes; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W_DEF = idx_width(NUM_CLASSES_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SCAN    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/fc_argmax_if.sv
// fc_argmax_if: frame-side signals of the argmax stage.
//   enable      : frame active (low aborts the frame)
//   score_in    : flattened signed scores, class i at [i*SCORE_W +: SCORE_W]
//   score_done  : per-neuron done flags
//   class_idx   : winning class index
//   done_argmax : result valid, held while enable stays high
//   busy        : high while capturing or scanning
//   max_score   : winning score (only when FC_ARGMAX_SCORE_OUT_EN is defined)
// master = score producer / result consumer, slave = fc_argmax.
interface fc_argmax_if
  import fc_argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int unsigned SCORE_W     = SCORE_W_DEF,
  parameter int unsigned IDX_W       = IDX_W_DEF
) ();

  logic                             enable;
  logic [NUM_CLASSES*SCORE_W-1:0]   score_in;
  logic [NUM_CLASSES-1:0]           score_done;
  logic [IDX_W-1:0]                 class_idx;
  logic                             done_argmax;
  logic                             busy;
`ifdef FC_ARGMAX_SCORE_OUT_EN
  logic signed [SCORE_W-1:0]        max_score;

  modport master (
    output enable, score_in, score_done,
    input  class_idx, done_argmax, busy, max_score
  );

  modport slave (
    input  enable, score_in, score_done,
    output class_idx, done_argmax, busy, max_score
  );
`else
  modport master (
    output enable, score_in, score_done,
    input  class_idx, done_argmax, busy
  );

  modport slave (
    input  enable, score_in, score_done,
    output class_idx, done_argmax, busy
  );
`endif

endinterface

// File: rtl/fc_score_bank.sv
// fc_score_bank: per-frame capture registers for the fc output scores.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : drop all capture flags (frame aborted)
//   cap_en      : capture window open
//   score_in    : flattened signed scores
//   score_done  : per-class done flags
//   ptr         : read index for the scan
//   rd_score    : bank[ptr]
//   bank0_next  : bank[0] as it will be after this edge
//   all_next    : every class will be captured after this edge
module fc_score_bank
  import fc_argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int unsigned SCORE_W     = SCORE_W_DEF,
  parameter int unsigned IDX_W       = IDX_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           cap_en,
  input  logic [NUM_CLASSES*SCORE_W-1:0] score_in,
  input  logic [NUM_CLASSES-1:0]         score_done,
  input  logic [IDX_W-1:0]               ptr,
  output logic signed [SCORE_W-1:0]      rd_score,
  output logic signed [SCORE_W-1:0]      bank0_next,
  output logic                           all_next
);

  logic signed [SCORE_W-1:0] bank [NUM_CLASSES];
  logic [NUM_CLASSES-1:0]    cap_mask;
  logic [NUM_CLASSES-1:0]    new_cap;
  logic [NUM_CLASSES-1:0]    mask_next;

  // A class is taken only on the first cycle its flag is seen in the window.
  always_comb begin
    new_cap   = score_done & ~cap_mask & {NUM_CLASSES{cap_en}};
    mask_next = cap_mask | new_cap;
    all_next  = &mask_next;
    // Lets the FSM seed the scan with a score that lands on the same edge.
    bank0_next = new_cap[0] ? score_in[SCORE_W-1:0] : bank[0];
  end

  always_comb begin
    rd_score = '0;
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      if (ptr == IDX_W'(i)) rd_score = bank[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_mask <= '0;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) bank[i] <= '0;
    end else begin
      cap_mask <= clear ? '0 : mask_next;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
        if (new_cap[i]) bank[i] <= score_in[i*SCORE_W +: SCORE_W];
      end
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// fc_argmax: captures one score per fc output neuron per frame, then scans the
// captured bank one signed compare per cycle and reports the winning index.
// Ties resolve to the lowest index.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fc_argmax_if.slave (enable, score_in, score_done in;
//              class_idx, done_argmax, busy out)
// Optional: define FC_ARGMAX_SCORE_OUT_EN to add bus.max_score, the winning
// score, updated together with class_idx.
module fc_argmax
  import fc_argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int unsigned SCORE_W     = SCORE_W_DEF,
  parameter int unsigned IDX_W       = IDX_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fc_argmax_if.slave    bus
);

  state_t                    state;
  logic [IDX_W-1:0]          ptr;
  logic signed [SCORE_W-1:0] best;
  logic [IDX_W-1:0]          best_idx;
  logic [IDX_W-1:0]          idx_reg;
  logic                      done_reg;
  logic                      busy_reg;

  logic signed [SCORE_W-1:0] rd_score;
  logic signed [SCORE_W-1:0] bank0_next;
  logic                      all_next;
  logic signed [SCORE_W-1:0] cand;
  logic [IDX_W-1:0]          cand_idx;
  logic                      cap_en;

  assign cap_en = bus.enable && (state == ST_CAPTURE);

  fc_score_bank #(
    .NUM_CLASSES (NUM_CLASSES),
    .SCORE_W     (SCORE_W),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .clear      (!bus.enable),
    .cap_en     (cap_en),
    .score_in   (bus.score_in),
    .score_done (bus.score_done),
    .ptr        (ptr),
    .rd_score   (rd_score),
    .bank0_next (bank0_next),
    .all_next   (all_next)
  );

  // Strictly greater keeps the earlier index on ties.
  always_comb begin
    if (rd_score > best) begin
      cand     = rd_score;
      cand_idx = ptr;
    end else begin
      cand     = best;
      cand_idx = best_idx;
    end
  end

`ifdef FC_ARGMAX_SCORE_OUT_EN
  logic signed [SCORE_W-1:0] max_reg;
  assign bus.max_score = max_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      best     <= '0;
      best_idx <= '0;
      idx_reg  <= '0;
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
`ifdef FC_ARGMAX_SCORE_OUT_EN
      max_reg  <= '0;
`endif
    end else if (!bus.enable) begin
      // Abort: result registers keep their last value.
      state    <= ST_IDLE;
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_CAPTURE;
          busy_reg <= 1'b1;
        end
        ST_CAPTURE: begin
          if (all_next) begin
            best     <= bank0_next;
            best_idx <= '0;
            ptr      <= IDX_W'(1);
            if (NUM_CLASSES == 1) begin
              idx_reg  <= '0;
              done_reg <= 1'b1;
              busy_reg <= 1'b0;
              state    <= ST_DONE;
`ifdef FC_ARGMAX_SCORE_OUT_EN
              max_reg  <= bank0_next;
`endif
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          best     <= cand;
          best_idx <= cand_idx;
          ptr      <= ptr + IDX_W'(1);
          if (ptr == IDX_W'(NUM_CLASSES - 1)) begin
            idx_reg  <= cand_idx;
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            state    <= ST_DONE;
`ifdef FC_ARGMAX_SCORE_OUT_EN
            max_reg  <= cand;
`endif
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.class_idx   = idx_reg;
  assign bus.done_argmax = done_reg;
  assign bus.busy        = busy_reg;

endmodule
